// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: multi-cycle multiply/divide unit for the EX stage.
// Owns the HI/LO registers. mult/multu/div/divu compute their 64-bit result
// at acceptance into hold registers, then hold Busy for a fixed latency and
// commit HI/LO on the last busy edge. mthi/mtlo write in one edge.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   MDUOp  operation select (1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//          6 mtlo, 7 mfhi, 8 mflo, others none)
//   A, B   rs / rt operands (already forwarded)
//   Busy   high while a mult/div is in flight
//   HI, LO architectural registers
//   Out    combinational read: HI on mfhi, LO on mflo, else 0
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        hi_nxt, lo_nxt;
    logic [31:0]        hold_hi, hold_lo, hold_hi_nxt, hold_lo_nxt;
    logic               hold_wr, hold_wr_nxt;

    // Arithmetic datapath (operands used only at acceptance)
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, sq_mag, sr_mag, sq, sr, uq, ur;
    logic        div_zero;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u   = {32'd0, A} * {32'd0, B};
    assign div_zero = (B == 32'd0);

    // Signed divide via magnitudes; this also makes 0x80000000 / -1 wrap
    // to 0x80000000 with remainder 0 without relying on signed overflow.
    assign abs_a  = A[31] ? (~A + 32'd1) : A;
    assign abs_b  = B[31] ? (~B + 32'd1) : B;
    assign sq_mag = div_zero ? 32'd0 : (abs_a / abs_b);
    assign sr_mag = div_zero ? 32'd0 : (abs_a % abs_b);
    assign sq     = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign sr     = A[31] ? (~sr_mag + 32'd1) : sr_mag;
    assign uq     = div_zero ? 32'd0 : (A / B);
    assign ur     = div_zero ? 32'd0 : (A % B);

    // State, counter, HI/LO, hold registers and registered Busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            hold_hi <= 32'd0;
            hold_lo <= 32'd0;
            hold_wr <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            HI      <= hi_nxt;
            LO      <= lo_nxt;
            hold_hi <= hold_hi_nxt;
            hold_lo <= hold_lo_nxt;
            hold_wr <= hold_wr_nxt;
            Busy    <= (state_nxt == BUSY);
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = HI;
        lo_nxt      = LO;
        hold_hi_nxt = hold_hi;
        hold_lo_nxt = hold_lo;
        hold_wr_nxt = hold_wr;
        case (state)
            IDLE: begin
                case (MDUOp)
                    OP_MULT: begin
                        hold_hi_nxt = prod_s[63:32];
                        hold_lo_nxt = prod_s[31:0];
                        hold_wr_nxt = 1'b1;
                        cnt_nxt     = CNT_W'(MULT_CYCLES);
                        state_nxt   = BUSY;
                    end
                    OP_MULTU: begin
                        hold_hi_nxt = prod_u[63:32];
                        hold_lo_nxt = prod_u[31:0];
                        hold_wr_nxt = 1'b1;
                        cnt_nxt     = CNT_W'(MULT_CYCLES);
                        state_nxt   = BUSY;
                    end
                    OP_DIV: begin
                        hold_hi_nxt = sr;
                        hold_lo_nxt = sq;
                        hold_wr_nxt = !div_zero;
                        cnt_nxt     = CNT_W'(DIV_CYCLES);
                        state_nxt   = BUSY;
                    end
                    OP_DIVU: begin
                        hold_hi_nxt = ur;
                        hold_lo_nxt = uq;
                        hold_wr_nxt = !div_zero;
                        cnt_nxt     = CNT_W'(DIV_CYCLES);
                        state_nxt   = BUSY;
                    end
                    OP_MTHI: hi_nxt = A;
                    OP_MTLO: lo_nxt = A;
                    default: ;
                endcase
            end
            BUSY: begin
                // Last busy edge commits the result unless it was a divide by zero
                if (cnt <= CNT_W'(1)) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    hold_wr_nxt = 1'b0;
                    if (hold_wr) begin
                        hi_nxt = hold_hi;
                        lo_nxt = hold_lo;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational mfhi/mflo read port
    always_comb begin
        Out = 32'd0;
        if (MDUOp == OP_MFHI) Out = HI;
        else if (MDUOp == OP_MFLO) Out = LO;
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb_e_mdu_ctrl: table-driven vectors for e_mdu_ctrl plus hand-written
// sequences for divide-by-zero, ops ignored while busy, back-to-back
// acceptance and asynchronous reset mid-operation.
module tb_e_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    int total = 0;
    int bad   = 0;

    e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .Out   (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present one op for one cycle, then count Busy cycles and check HI/LO.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cyc, input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag);
        logic [31:0] hi0, lo0;
        int          n;
        logic        held;
        hi0   = HI;
        lo0   = LO;
        MDUOp = op;
        A     = a;
        B     = b;
        @(posedge clk); #1;
        MDUOp = 4'd0;
        A     = $urandom;
        B     = $urandom;
        n     = 0;
        held  = 1'b1;
        while (Busy && n < 200) begin
            n++;
            if (HI !== hi0 || LO !== lo0) held = 1'b0;
            @(posedge clk); #1;
        end
        check({tag, " busy cycles"}, 32'(n), 32'(cyc));
        if (cyc > 0) check({tag, " hi/lo held while busy"}, {31'd0, held}, 32'd1);
        check({tag, " HI"}, HI, ehi);
        check({tag, " LO"}, LO, elo);
    endtask

    task automatic check_out(input logic [3:0] op, input logic [31:0] exp, input string tag);
        MDUOp = op;
        #1;
        check(tag, Out, exp);
        MDUOp = 4'd0;
    endtask

    initial begin
        int n;

        vecs[0] = '{4'd5, 32'h12345678, 32'h0,        0,  32'h12345678, 32'h00000000};
        vecs[1] = '{4'd6, 32'h9ABCDEF0, 32'h0,        0,  32'h12345678, 32'h9ABCDEF0};
        vecs[2] = '{4'd1, 32'hFFFFFFFE, 32'h3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[3] = '{4'd2, 32'hFFFFFFFE, 32'h3,        5,  32'h00000002, 32'hFFFFFFFA};
        vecs[4] = '{4'd3, 32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{4'd4, 32'h7,        32'h2,        10, 32'h00000001, 32'h00000003};
        vecs[6] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[7] = '{4'd1, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
        vecs[8] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[9] = '{4'd3, 32'h7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};

        reset = 1'b0;
        MDUOp = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        #12;
        check("reset Busy", {31'd0, Busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors; each op is presented in the first idle cycle
        // after the previous one completes.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].hi, vecs[i].lo,
                   $sformatf("vec%0d", i));
            if (i == 1) begin
                check_out(4'd7, 32'h12345678, "mfhi Out");
                check_out(4'd8, 32'h9ABCDEF0, "mflo Out");
                check_out(4'd0, 32'h0, "none Out");
                check_out(4'd9, 32'h0, "op9 Out");
            end
        end

        // Divide by zero: full latency, HI/LO untouched
        run_op(4'd5, 32'hAAAA0000, 32'h0, 0, 32'hAAAA0000, 32'hFFFFFFFD, "pre mthi");
        run_op(4'd6, 32'h0000BBBB, 32'h0, 0, 32'hAAAA0000, 32'h0000BBBB, "pre mtlo");
        run_op(4'd3, 32'h5, 32'h0, 10, 32'hAAAA0000, 32'h0000BBBB, "div by 0");
        run_op(4'd4, 32'h5, 32'h0, 10, 32'hAAAA0000, 32'h0000BBBB, "divu by 0");

        // mtlo and a second mult during BUSY are ignored
        MDUOp = 4'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        check("ign busy rise", {31'd0, Busy}, 32'd1);
        MDUOp = 4'd6; A = 32'h0000DEAD;
        @(posedge clk); #1;
        MDUOp = 4'd1; A = 32'd100; B = 32'd100;
        @(posedge clk); #1;
        MDUOp = 4'd0;
        n = 2;
        while (Busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check("ign busy cycles", 32'(n), 32'd5);
        check("ign HI", HI, 32'd0);
        check("ign LO", LO, 32'd12);

        // Accepted in the first idle cycle after Busy falls
        run_op(4'd1, 32'd5, 32'd6, 5, 32'd0, 32'd30, "back2back");

        // Asynchronous reset in the 4th busy cycle of a divide
        MDUOp = 4'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        MDUOp = 4'd0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre-reset Busy", {31'd0, Busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async rst Busy", {31'd0, Busy}, 32'd0);
        check("async rst HI", HI, 32'd0);
        check("async rst LO", LO, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("post rst Busy", {31'd0, Busy}, 32'd0);
        check("post rst HI", HI, 32'd0);
        check("post rst LO", LO, 32'd0);
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "post rst mult");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, reached %0t expected under 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller for the EX stage of the 5-stage MIPS pipeline.
- Sits beside the single-cycle ALU and owns the HI/LO architectural registers.
- Executes mult/multu/div/divu with fixed latency, plus mthi/mtlo/mfhi/mflo.
- Drives Busy so the hazard unit can stall any MDU instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (legal range ≥1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (legal range ≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- MDUOp  input  4  operation select, valid for one cycle per instruction. Encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 none.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- Busy  output  1  high while a mult/div is in progress.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- Out  output  32  combinational read result: HI when MDUOp=7, LO when MDUOp=8, else 0.

Behaviour:
- Reset (reset=0, any time, asynchronous): state=IDLE, counter=0, Busy=0, HI=0, LO=0, pending result discarded.
- An in-flight operation interrupted by reset never writes HI/LO.
- FSM states: IDLE and BUSY.
- IDLE, MDUOp in 1..4 at edge k:
  - Compute and latch the 64-bit result into internal hold registers at edge k.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY:
  - Busy=1 for exactly N cycles, covering cycles k+1 through k+N.
  - Counter decrements each edge.
  - At the edge where counter==1, HI/LO are written from the hold registers; state returns to IDLE, Busy=0 and counter=0 from that edge on.
  - New HI/LO values are visible starting in cycle k+N+1.
- Back-to-back operations: an op presented in the first IDLE cycle after completion is accepted normally.
- Any MDUOp presented while BUSY (ops 1–6) is ignored; no state change.
- The hazard unit guarantees this never happens: it stalls in D while Busy=1 or E holds ops 1–4.
- mthi/mtlo in IDLE: HI←A or LO←A at the same edge; no Busy.
- mfhi/mflo: Out is purely combinational from the current HI/LO.
- mult: signed 32×32 to 64-bit product; HI=upper 32 bits, LO=lower 32 bits.
- multu: unsigned 32×32 to 64-bit product; HI=upper 32 bits, LO=lower 32 bits.
- div:
  - LO=signed quotient, truncated toward zero.
  - HI=remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divide by zero (B=0, div or divu): the operation still runs the full DIV_CYCLES with Busy high, but HI/LO keep their prior values.
- Operands are captured at acceptance. Changes to A/B during BUSY have no effect.

Test Plan:
- Reset, then mthi A=0x12345678 and mtlo A=0x9ABCDEF0 on consecutive cycles → HI=0x12345678, LO=0x9ABCDEF0 one edge after each; mfhi/mflo Out matches; Busy never rises.
- mult A=0xFFFFFFFE(-2), B=3 → Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle k+6; multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2 → after exactly 10 Busy cycles LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); divu A=7, B=2 → LO=3, HI=1; div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0xAAAA0000 and LO=0x0000BBBB, then div A=5, B=0 → Busy high for 10 cycles; HI and LO unchanged afterwards.
- Present mtlo A=0xDEAD and a second mult during BUSY → both ignored; the final LO equals the first mult's result. A mult presented the cycle Busy falls → accepted, Busy re-rises the next cycle.
- Assert reset=0 mid-div at cycle 4 → Busy=0, HI=LO=0 immediately (asynchronous); after release, the next mult completes normally in 5 cycles.
